// File: rtl/dmi_host_bridge_if.sv
// Host <-> bridge <-> DMI signal bundle.
//   host_cmd_*  : host command channel (valid/ready, addr[6:0], op[1:0], data[31:0])
//   host_rsp_*  : host response channel (valid/ready, resp[1:0], data[31:0], timeout)
//   dmi_req_*   : DMI request channel (valid/ready, bits_addr/op/data)
//   dmi_resp_*  : DMI response channel (valid/ready, bits_resp/data)
// modport slave  : the bridge's view (drives host_cmd_ready, host_rsp_*, dmi_req_*, dmi_resp_ready)
// modport master : the environment's view (host and DMI target), directions mirrored
interface dmi_host_bridge_if;
    logic        host_cmd_valid;
    logic        host_cmd_ready;
    logic [6:0]  host_cmd_addr;
    logic [1:0]  host_cmd_op;
    logic [31:0] host_cmd_data;

    logic        host_rsp_valid;
    logic        host_rsp_ready;
    logic [1:0]  host_rsp_resp;
    logic [31:0] host_rsp_data;
    logic        host_rsp_timeout;

    logic        dmi_req_valid;
    logic        dmi_req_ready;
    logic [6:0]  dmi_req_bits_addr;
    logic [1:0]  dmi_req_bits_op;
    logic [31:0] dmi_req_bits_data;

    logic        dmi_resp_valid;
    logic        dmi_resp_ready;
    logic [1:0]  dmi_resp_bits_resp;
    logic [31:0] dmi_resp_bits_data;

    modport slave (
        input  host_cmd_valid, host_cmd_addr, host_cmd_op, host_cmd_data,
        output host_cmd_ready,
        output host_rsp_valid, host_rsp_resp, host_rsp_data, host_rsp_timeout,
        input  host_rsp_ready,
        output dmi_req_valid, dmi_req_bits_addr, dmi_req_bits_op, dmi_req_bits_data,
        input  dmi_req_ready,
        input  dmi_resp_valid, dmi_resp_bits_resp, dmi_resp_bits_data,
        output dmi_resp_ready
    );

    modport master (
        output host_cmd_valid, host_cmd_addr, host_cmd_op, host_cmd_data,
        input  host_cmd_ready,
        input  host_rsp_valid, host_rsp_resp, host_rsp_data, host_rsp_timeout,
        output host_rsp_ready,
        input  dmi_req_valid, dmi_req_bits_addr, dmi_req_bits_op, dmi_req_bits_data,
        output dmi_req_ready,
        output dmi_resp_valid, dmi_resp_bits_resp, dmi_resp_bits_data,
        input  dmi_resp_ready
    );
endinterface

// File: rtl/dmi_host_bridge.sv
// Single-outstanding host-to-DMI bridge.
// Accepts one host command, forwards it as a DMI request, waits for the DMI
// response and returns it to the host. A 16-bit counter aborts a transaction
// that spends TIMEOUT_CYCLES cycles in REQ+WAIT (0 disables the abort).
// Ports:
//   clk_i         : clock, rising edge
//   rst_i         : asynchronous active-high reset
//   bus_if        : dmi_host_bridge_if.slave, host and DMI channels
//   busy_o        : high whenever the FSM is not IDLE
//   stale_count_o : saturating count of DMI responses discarded outside WAIT
module dmi_host_bridge #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    dmi_host_bridge_if.slave       bus_if,
    output logic                   busy_o,
    output logic [7:0]             stale_count_o
);
    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_RSP} state_t;

    localparam bit          TMO_EN       = (TIMEOUT_CYCLES != 0);
    localparam int          TMO_LAST_INT = TMO_EN ? (TIMEOUT_CYCLES - 1) : 0;
    localparam logic [15:0] TMO_LAST     = 16'(TMO_LAST_INT);

    state_t      state_q, state_d;
    logic [15:0] tmo_cnt_q, tmo_cnt_d;
    logic [6:0]  addr_q, addr_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  resp_q, resp_d;
    logic [31:0] rdata_q, rdata_d;
    logic        tmo_flag_q, tmo_flag_d;
    logic [7:0]  stale_q, stale_d;
    logic        tmo_hit;

    assign tmo_hit = TMO_EN && (tmo_cnt_q == TMO_LAST);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            tmo_cnt_q  <= '0;
            addr_q     <= '0;
            op_q       <= '0;
            wdata_q    <= '0;
            resp_q     <= '0;
            rdata_q    <= '0;
            tmo_flag_q <= 1'b0;
            stale_q    <= '0;
        end else begin
            state_q    <= state_d;
            tmo_cnt_q  <= tmo_cnt_d;
            addr_q     <= addr_d;
            op_q       <= op_d;
            wdata_q    <= wdata_d;
            resp_q     <= resp_d;
            rdata_q    <= rdata_d;
            tmo_flag_q <= tmo_flag_d;
            stale_q    <= stale_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        tmo_cnt_d  = tmo_cnt_q;
        addr_d     = addr_q;
        op_d       = op_q;
        wdata_d    = wdata_q;
        resp_d     = resp_q;
        rdata_d    = rdata_q;
        tmo_flag_d = tmo_flag_q;
        stale_d    = stale_q;

        case (state_q)
            ST_IDLE: begin
                if (bus_if.host_cmd_valid) begin
                    addr_d    = bus_if.host_cmd_addr;
                    op_d      = bus_if.host_cmd_op;
                    wdata_d   = bus_if.host_cmd_data;
                    tmo_cnt_d = '0;
                    state_d   = ST_REQ;
                end
            end
            ST_REQ: begin
                tmo_cnt_d = tmo_cnt_q + 16'd1;
                // A handshake in the last allowed cycle still wins over the abort.
                if (bus_if.dmi_req_ready) begin
                    state_d = ST_WAIT;
                end else if (tmo_hit) begin
                    resp_d     = 2'b10;
                    rdata_d    = '0;
                    tmo_flag_d = 1'b1;
                    state_d    = ST_RSP;
                end
            end
            ST_WAIT: begin
                tmo_cnt_d = tmo_cnt_q + 16'd1;
                if (bus_if.dmi_resp_valid) begin
                    resp_d     = bus_if.dmi_resp_bits_resp;
                    rdata_d    = bus_if.dmi_resp_bits_data;
                    tmo_flag_d = 1'b0;
                    state_d    = ST_RSP;
                end else if (tmo_hit) begin
                    resp_d     = 2'b10;
                    rdata_d    = '0;
                    tmo_flag_d = 1'b1;
                    state_d    = ST_RSP;
                end
            end
            ST_RSP: begin
                if (bus_if.host_rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // dmi_resp_ready is always high, so any response outside WAIT is
        // swallowed; count it so stray/late responses remain visible.
        if (bus_if.dmi_resp_valid && (state_q != ST_WAIT) && (stale_q != 8'hFF)) begin
            stale_d = stale_q + 8'd1;
        end
    end

    assign bus_if.host_cmd_ready    = (state_q == ST_IDLE);
    assign bus_if.dmi_req_valid     = (state_q == ST_REQ);
    assign bus_if.dmi_req_bits_addr = addr_q;
    assign bus_if.dmi_req_bits_op   = op_q;
    assign bus_if.dmi_req_bits_data = wdata_q;
    assign bus_if.dmi_resp_ready    = 1'b1;
    assign bus_if.host_rsp_valid    = (state_q == ST_RSP);
    assign bus_if.host_rsp_resp     = resp_q;
    assign bus_if.host_rsp_data     = rdata_q;
    assign bus_if.host_rsp_timeout  = tmo_flag_q;
    assign busy_o                   = (state_q != ST_IDLE);
    assign stale_count_o            = stale_q;
endmodule

// File: tb/tb_dmi_host_bridge.sv
module tb_dmi_host_bridge;
    localparam int TMO = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dmi_host_bridge_if bus ();
    logic       busy;
    logic [7:0] stale;

    dmi_host_bridge #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .bus_if        (bus),
        .busy_o        (busy),
        .stale_count_o (stale)
    );

    typedef struct packed {
        logic [6:0]  addr;
        logic [1:0]  op;
        logic [31:0] data;
    } req_t;

    typedef struct packed {
        logic [1:0]  resp;
        logic [31:0] data;
        logic        tmo;
    } rsp_t;

    req_t exp_req[$];
    rsp_t exp_rsp[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // monitor-private state
    bit   req_held = 0;
    bit   rsp_held = 0;
    req_t held_req, cur_req, pop_req;
    rsp_t held_rsp, cur_rsp, pop_rsp;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    task automatic do_cmd(input logic [6:0] a, input logic [1:0] o, input logic [31:0] d,
                          input bit push_req, input rsp_t r);
        @(negedge clk);
        bus.host_cmd_valid = 1'b1;
        bus.host_cmd_addr  = a;
        bus.host_cmd_op    = o;
        bus.host_cmd_data  = d;
        if (push_req) exp_req.push_back('{addr: a, op: o, data: d});
        exp_rsp.push_back(r);
        @(negedge clk);
        bus.host_cmd_valid = 1'b0;
        check("cmd_to_req_latency", 64'(bus.dmi_req_valid), 64'(1));
    endtask

    task automatic dmi_respond(input logic [1:0] r, input logic [31:0] d);
        bus.dmi_resp_valid     = 1'b1;
        bus.dmi_resp_bits_resp = r;
        bus.dmi_resp_bits_data = d;
        @(negedge clk);
        bus.dmi_resp_valid     = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("return_to_idle", 64'(busy), 64'(0));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_ready"}, 64'(bus.host_cmd_ready), 64'(1));
        check({tag, "_req_valid"}, 64'(bus.dmi_req_valid), 64'(0));
        check({tag, "_req_fields"}, 64'({bus.dmi_req_bits_addr, bus.dmi_req_bits_op, bus.dmi_req_bits_data}), 64'(0));
        check({tag, "_rsp_valid"}, 64'(bus.host_rsp_valid), 64'(0));
        check({tag, "_rsp_fields"}, 64'({bus.host_rsp_resp, bus.host_rsp_data, bus.host_rsp_timeout}), 64'(0));
        check({tag, "_busy"}, 64'(busy), 64'(0));
        check({tag, "_stale"}, 64'(stale), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.host_cmd_valid     = 1'b0;
        bus.host_cmd_addr      = '0;
        bus.host_cmd_op        = '0;
        bus.host_cmd_data      = '0;
        bus.host_rsp_ready     = 1'b1;
        bus.dmi_req_ready      = 1'b1;
        bus.dmi_resp_valid     = 1'b0;
        bus.dmi_resp_bits_resp = '0;
        bus.dmi_resp_bits_data = '0;

        // Scoreboard monitor: samples mid-cycle, after stimulus has settled.
        fork
            forever begin
                @(negedge clk);
                #3;
                if (rst) begin
                    req_held = 0;
                    rsp_held = 0;
                end else begin
                    if (bus.dmi_req_valid) begin
                        cur_req = '{addr: bus.dmi_req_bits_addr, op: bus.dmi_req_bits_op,
                                    data: bus.dmi_req_bits_data};
                        if (req_held) check("req_stable", 64'(cur_req), 64'(held_req));
                        if (bus.dmi_req_ready) begin
                            if (exp_req.size() == 0) begin
                                vectors++;
                                miscompares++;
                                $display("FAIL unexpected_req: got request 0x%0h, expected none", cur_req);
                            end else begin
                                pop_req = exp_req.pop_front();
                                check("dmi_req", 64'(cur_req), 64'(pop_req));
                            end
                            req_held = 0;
                        end else begin
                            req_held = 1;
                            held_req = cur_req;
                        end
                    end else begin
                        req_held = 0;
                    end

                    if (bus.host_rsp_valid) begin
                        cur_rsp = '{resp: bus.host_rsp_resp, data: bus.host_rsp_data,
                                    tmo: bus.host_rsp_timeout};
                        if (rsp_held) check("rsp_stable", 64'(cur_rsp), 64'(held_rsp));
                        if (bus.host_rsp_ready) begin
                            if (exp_rsp.size() == 0) begin
                                vectors++;
                                miscompares++;
                                $display("FAIL unexpected_rsp: got response 0x%0h, expected none", cur_rsp);
                            end else begin
                                pop_rsp = exp_rsp.pop_front();
                                check("host_rsp", 64'(cur_rsp), 64'(pop_rsp));
                            end
                            rsp_held = 0;
                        end else begin
                            rsp_held = 1;
                            held_rsp = cur_rsp;
                        end
                    end else begin
                        rsp_held = 0;
                    end
                end
            end
        join_none

        // Reset state
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // Read: immediate request accept, response two cycles later
        do_cmd(7'h11, 2'd1, 32'h0, 1, '{resp: 2'd0, data: 32'hDEADBEEF, tmo: 1'b0});
        @(negedge clk);
        dmi_respond(2'd0, 32'hDEADBEEF);
        wait_idle();
        check("read_cmd_ready_after", 64'(bus.host_cmd_ready), 64'(1));

        // Backpressure on both channels
        bus.dmi_req_ready  = 1'b0;
        bus.host_rsp_ready = 1'b0;
        do_cmd(7'h2A, 2'd2, 32'h12345678, 1, '{resp: 2'd3, data: 32'hCAFEF00D, tmo: 1'b0});
        repeat (5) @(negedge clk);
        bus.dmi_req_ready = 1'b1;
        @(negedge clk);
        bus.dmi_req_ready = 1'b0;
        dmi_respond(2'd3, 32'hCAFEF00D);
        repeat (3) @(negedge clk);
        bus.host_rsp_ready = 1'b1;
        wait_idle();

        // Timeout in REQ: no request handshake, no response
        bus.host_rsp_ready = 1'b0;
        do_cmd(7'h33, 2'd0, 32'hA5A5A5A5, 0, '{resp: 2'd2, data: 32'h0, tmo: 1'b1});
        repeat (7) @(negedge clk);
        check("tmo_not_early", 64'(bus.host_rsp_valid), 64'(0));
        @(negedge clk);
        check("tmo_rsp_valid", 64'(bus.host_rsp_valid), 64'(1));
        check("tmo_req_dropped", 64'(bus.dmi_req_valid), 64'(0));
        bus.host_rsp_ready = 1'b1;
        wait_idle();
        bus.dmi_req_ready = 1'b1;
        dmi_respond(2'd0, 32'h00001234);
        check("late_rsp_stale", 64'(stale), 64'(1));

        // Race: response arrives in the exact timeout cycle
        do_cmd(7'h44, 2'd1, 32'h0, 1, '{resp: 2'd1, data: 32'h0BADF00D, tmo: 1'b0});
        repeat (7) @(negedge clk);
        dmi_respond(2'd1, 32'h0BADF00D);
        wait_idle();
        check("race_stale_unchanged", 64'(stale), 64'(1));

        // Asynchronous reset while in WAIT
        do_cmd(7'h05, 2'd1, 32'h0, 1, '{resp: 2'd0, data: 32'h0, tmo: 1'b0});
        @(negedge clk);
        #2;
        rst = 1'b1;
        exp_rsp.delete();
        #1;
        check_reset_outputs("async_rst");
        @(negedge clk);
        rst = 1'b0;
        dmi_respond(2'd0, 32'h00000099);
        check("post_rst_late_stale", 64'(stale), 64'(1));

        // Normal traffic after reset, all ops forwarded untouched
        do_cmd(7'h7F, 2'd3, 32'hFFFFFFFF, 1, '{resp: 2'd0, data: 32'h55AA55AA, tmo: 1'b0});
        @(negedge clk);
        dmi_respond(2'd0, 32'h55AA55AA);
        wait_idle();
        do_cmd(7'h00, 2'd0, 32'h00000000, 1, '{resp: 2'd2, data: 32'h00000001, tmo: 1'b0});
        @(negedge clk);
        dmi_respond(2'd2, 32'h00000001);
        wait_idle();

        // Stray responses while idle saturate the stale counter
        bus.dmi_resp_valid = 1'b1;
        repeat (300) @(negedge clk);
        bus.dmi_resp_valid = 1'b0;
        @(negedge clk);
        check("stale_saturated", 64'(stale), 64'(255));
        check("stray_stays_idle", 64'(busy), 64'(0));

        repeat (3) @(negedge clk);
        check("req_queue_drained", 64'(exp_req.size()), 64'(0));
        check("rsp_queue_drained", 64'(exp_rsp.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/dmi_host_bridge.md
DMI_HOST_BRIDGE -- requirements
Module: dmi_host_bridge

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1024: cycles allowed in REQ+WAIT before abort; range 0..65535; 0 disables the timeout.
REQ-002 clock  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 host_cmd_valid  input  1  host command offered.
REQ-005 host_cmd_ready  output  1  bridge accepts command.
REQ-006 host_cmd_addr / host_cmd_op / host_cmd_data  input  7/2/32  DMI address, op, write data.
REQ-007 host_rsp_valid  output  1  result available.
REQ-008 host_rsp_ready  input  1  host consumes result.
REQ-009 host_rsp_resp / host_rsp_data / host_rsp_timeout  output  2/32/1  DMI resp code, read data, timeout flag.
REQ-010 dmi_req_valid  output  1; dmi_req_ready  input  1; dmi_req_bits_addr / _op / _data  output  7/2/32: DMI request channel.
REQ-011 dmi_resp_valid  input  1; dmi_resp_ready  output  1; dmi_resp_bits_resp / _data  input  2/32: DMI response channel.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 stale_count  output  8  saturating count of discarded DMI responses.

Function
REQ-014 The block SHALL implement a four-state FSM: IDLE, REQ, WAIT, RSP; exactly one transaction is outstanding at a time.
REQ-015 IDLE: host_cmd_ready=1; on host_cmd_valid, capture addr/op/data, clear the timeout counter, go to REQ.
REQ-016 REQ: dmi_req_valid=1 with the captured fields, held stable until handshake; on dmi_req_ready go to WAIT.
REQ-017 WAIT: dmi_resp_ready=1; on dmi_resp_valid capture resp/data, clear host_rsp_timeout, go to RSP.
REQ-018 RSP: host_rsp_valid=1, outputs stable; on host_rsp_ready go to IDLE.
REQ-019 All ops (0..3) SHALL be forwarded unmodified; the bridge does not interpret op.
REQ-020 Latency: command accepted in cycle N drives dmi_req_valid in N+1; response accepted in cycle M drives host_rsp_valid in M+1.
REQ-021 Back-to-back: host_cmd_ready SHALL be high in the cycle after the RSP handshake (IDLE).
REQ-022 The 16-bit timeout counter SHALL increment each cycle in REQ and WAIT; when it equals TIMEOUT_CYCLES-1 with no handshake that cycle, go to RSP with resp=2'b10, data=0, host_rsp_timeout=1, and deassert dmi_req_valid.
REQ-023 Simultaneous handshake and timeout in the same cycle: the handshake SHALL win (REQ->WAIT, or WAIT->RSP with real data, timeout=0).
REQ-024 In IDLE, REQ and RSP, dmi_resp_ready SHALL be 1; any dmi_resp_valid in those states is discarded and increments stale_count, saturating at 255.
REQ-025 host_cmd_valid outside IDLE SHALL be ignored (host_cmd_ready=0).
REQ-026 TIMEOUT_CYCLES=0: the counter SHALL never trigger; the FSM waits indefinitely.

Reset
REQ-027 On reset assertion, asynchronously: state=IDLE, host_cmd_ready=1, dmi_req_valid=0, host_rsp_valid=0, host_rsp_resp=0, host_rsp_data=0, host_rsp_timeout=0, busy=0, stale_count=0, counter=0, captured fields=0.
REQ-028 Reset mid-transaction SHALL abandon it with no host response; a late DMI response after reset counts as stale.

Verification
REQ-029 Read: cmd addr=0x11 op=1; dmi_req_ready=1 immediately; dmi_resp resp=0 data=0xDEADBEEF two cycles later -> host_rsp_valid with resp=0, data=0xDEADBEEF, timeout=0; request seen exactly once with addr=0x11, op=1.
REQ-030 Backpressure: dmi_req_ready low 5 cycles, host_rsp_ready low 3 cycles -> request fields stable throughout, single request, response held stable until accepted.
REQ-031 Timeout: TIMEOUT_CYCLES=8, dmi_resp_valid never asserted -> host_rsp_valid at the 8th cycle after REQ entry with resp=2, data=0, timeout=1; late response then -> stale_count=1.
REQ-032 Race: dmi_resp_valid in the exact timeout cycle -> real data returned, timeout=0, stale_count unchanged.
REQ-033 Reset asserted in WAIT -> all outputs at REQ-027 values immediately, without a clock edge; next command processes normally.
REQ-034 300 stray DMI responses while idle -> stale_count=255, FSM stays IDLE.
